// File: rtl/wr_recovery_ctrl.sv
// Recovery sequencer for the AXI write monitor: isolates, drains and
// resets the slave, then flushes the transaction tables and waits for SW.
module wr_recovery_ctrl #(
    parameter int unsigned MaxWrTxns   = 8,
    parameter int unsigned DrainCycles = 1024,
    parameter int unsigned RstCycles   = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       reset_req_i,
    input  logic       irq_clear_i,
    input  logic       aw_valid_i,
    input  logic       aw_ready_i,
    input  logic [7:0] aw_len_i,
    input  logic       w_valid_i,
    input  logic       w_ready_i,
    input  logic       b_valid_i,
    input  logic       b_ready_i,
    output logic       gate_aw_o,
    output logic       gate_w_o,
    output logic       slv_rst_no,
    output logic       txn_clear_o,
    output logic       drain_timeout_o,
    output logic       busy_o,
    output logic [2:0] state_o
);

    localparam int unsigned OutW  = $clog2(MaxWrTxns + 1);
    localparam int unsigned OwedW = $clog2(MaxWrTxns * 256 + 1);
    localparam int unsigned TmrW  = $clog2(DrainCycles + 1);
    localparam int unsigned RcW   = $clog2(RstCycles + 1);

    localparam logic [OutW-1:0] OutMax  = OutW'(MaxWrTxns);
    localparam logic [TmrW-1:0] TmrLoad = TmrW'(DrainCycles);
    localparam logic [RcW-1:0]  RcLast  = RcW'(RstCycles - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISOLATE = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_RESET   = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_WAIT_SW = 3'd5
    } state_e;

    state_e state_q;
    state_e state_d;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic count_en;

    logic [OutW-1:0]  out_cnt;
    logic [OutW-1:0]  out_nxt;
    logic [OwedW-1:0] beats_owed;
    logic [OwedW-1:0] owed_nxt;
    logic [OwedW:0]   owed_add;
    logic [OwedW:0]   owed_sum;

    logic [TmrW-1:0] tmr_q;
    logic            tmr_last;
    logic            tmr_load;
    logic [RcW-1:0]  rcnt_q;
    logic            rst_last;

    logic timeout_q;
    logic set_timeout;
    logic clr_timeout;

    assign aw_hs    = aw_valid_i & aw_ready_i;
    assign w_hs     = w_valid_i & w_ready_i;
    assign b_hs     = b_valid_i & b_ready_i;
    assign count_en = (state_q != ST_RESET);

    // The timer is "reaching zero" in the cycle it holds one.
    assign tmr_last = (tmr_q <= TmrW'(1));
    assign rst_last = (rcnt_q == RcLast);

    // Outstanding-transaction count, saturating at both ends.
    always_comb begin
        out_nxt = out_cnt;
        if (count_en) begin
            if (aw_hs && !b_hs && out_cnt != OutMax) begin
                out_nxt = out_cnt + 1'b1;
            end else if (!aw_hs && b_hs && out_cnt != '0) begin
                out_nxt = out_cnt - 1'b1;
            end
        end
    end

    // Owed W beats: add the burst length, retire one per W beat.
    always_comb begin
        owed_add = '0;
        owed_sum = {1'b0, beats_owed};
        owed_nxt = beats_owed;
        if (count_en) begin
            if (aw_hs) begin
                owed_add = (OwedW+1)'(aw_len_i) + 1'b1;
            end
            owed_sum = {1'b0, beats_owed} + owed_add;
            if (w_hs && owed_sum != '0) begin
                owed_sum = owed_sum - 1'b1;
            end
            if (owed_sum[OwedW]) begin
                owed_nxt = '1;
            end else begin
                owed_nxt = owed_sum[OwedW-1:0];
            end
        end
    end

    // Counter registers; cleared on the final slave-reset cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_cnt    <= '0;
            beats_owed <= '0;
        end else if (state_q == ST_RESET && rst_last) begin
            out_cnt    <= '0;
            beats_owed <= '0;
        end else begin
            out_cnt    <= out_nxt;
            beats_owed <= owed_nxt;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a clean drain takes priority over expiry.
    always_comb begin
        state_d     = state_q;
        set_timeout = 1'b0;
        clr_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (reset_req_i) begin
                    state_d = ST_ISOLATE;
                end
            end
            ST_ISOLATE: begin
                if (owed_nxt == '0) begin
                    state_d = ST_DRAIN;
                end else if (tmr_last) begin
                    state_d     = ST_RESET;
                    set_timeout = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (out_nxt == '0) begin
                    state_d = ST_RESET;
                end else if (tmr_last) begin
                    state_d     = ST_RESET;
                    set_timeout = 1'b1;
                end
            end
            ST_RESET: begin
                if (rst_last) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_WAIT_SW;
            end
            ST_WAIT_SW: begin
                if (irq_clear_i && !reset_req_i) begin
                    state_d     = ST_IDLE;
                    clr_timeout = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tmr_load = ((state_d == ST_ISOLATE) && (state_q != ST_ISOLATE)) ||
                      ((state_d == ST_DRAIN) && (state_q != ST_DRAIN));

    // Drain timer: reloads on entry to ISOLATE or DRAIN, counts down there.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tmr_q <= '0;
        end else if (tmr_load) begin
            tmr_q <= TmrLoad;
        end else if ((state_q == ST_ISOLATE || state_q == ST_DRAIN) &&
                     tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end

    // Slave-reset length counter, idle at zero outside RESET.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rcnt_q <= '0;
        end else if (state_q == ST_RESET && !rst_last) begin
            rcnt_q <= rcnt_q + 1'b1;
        end else begin
            rcnt_q <= '0;
        end
    end

    // Sticky timeout flag, held until software releases the block.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            timeout_q <= 1'b0;
        end else if (set_timeout) begin
            timeout_q <= 1'b1;
        end else if (clr_timeout) begin
            timeout_q <= 1'b0;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        gate_aw_o   = 1'b0;
        gate_w_o    = 1'b0;
        slv_rst_no  = 1'b1;
        txn_clear_o = 1'b0;
        case (state_q)
            ST_ISOLATE: begin
                gate_aw_o = 1'b1;
            end
            ST_DRAIN, ST_WAIT_SW: begin
                gate_aw_o = 1'b1;
                gate_w_o  = 1'b1;
            end
            ST_RESET: begin
                gate_aw_o  = 1'b1;
                gate_w_o   = 1'b1;
                slv_rst_no = 1'b0;
            end
            ST_CLEAR: begin
                gate_aw_o   = 1'b1;
                gate_w_o    = 1'b1;
                txn_clear_o = 1'b1;
            end
            default: begin
                gate_aw_o = 1'b0;
            end
        endcase
    end

    assign busy_o          = (state_q != ST_IDLE);
    assign state_o         = state_q;
    assign drain_timeout_o = timeout_q;

endmodule

// File: tb/tb_wr_recovery_ctrl.sv
// Bench for wr_recovery_ctrl: directed recovery scenarios followed by
// random traffic, all compared against a cycle reference model.
module tb_wr_recovery_ctrl;

    localparam int MAXT = 8;
    localparam int DRC  = 8;
    localparam int RSC  = 16;
    localparam int OWED_MAX = 4095;

    localparam int P_IDLE = 0;
    localparam int P_ISO  = 1;
    localparam int P_DRN  = 2;
    localparam int P_RST  = 3;
    localparam int P_CLR  = 4;
    localparam int P_WAIT = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       irq = 1'b0;
    logic       awv = 1'b0;
    logic       awr = 1'b0;
    logic [7:0] awlen = 8'd0;
    logic       wv = 1'b0;
    logic       wr = 1'b0;
    logic       bv = 1'b0;
    logic       br = 1'b0;

    logic       gate_aw;
    logic       gate_w;
    logic       slv_rst_n;
    logic       txn_clear;
    logic       drain_to;
    logic       busy;
    logic [2:0] state;

    wr_recovery_ctrl #(
        .MaxWrTxns  (MAXT),
        .DrainCycles(DRC),
        .RstCycles  (RSC)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .reset_req_i    (req),
        .irq_clear_i    (irq),
        .aw_valid_i     (awv),
        .aw_ready_i     (awr),
        .aw_len_i       (awlen),
        .w_valid_i      (wv),
        .w_ready_i      (wr),
        .b_valid_i      (bv),
        .b_ready_i      (br),
        .gate_aw_o      (gate_aw),
        .gate_w_o       (gate_w),
        .slv_rst_no     (slv_rst_n),
        .txn_clear_o    (txn_clear),
        .drain_timeout_o(drain_to),
        .busy_o         (busy),
        .state_o        (state)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    int m_ph   = P_IDLE;
    int m_out  = 0;
    int m_owed = 0;
    int m_tmr  = 0;
    int m_left = 0;
    bit m_flag = 1'b0;

    // per-scenario observations
    int rst_lo_cnt = 0;
    int clr_cnt    = 0;
    int busy_cnt   = 0;
    int drain_cnt  = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_update();
        bit aw;
        bit w;
        bit b;
        int nout;
        int nowed;
        int t;
        if (!rst_n) begin
            m_ph = P_IDLE;
            m_out = 0;
            m_owed = 0;
            m_tmr = 0;
            m_left = 0;
            m_flag = 1'b0;
            return;
        end
        aw = awv && awr;
        w  = wv && wr;
        b  = bv && br;
        nout  = m_out;
        nowed = m_owed;
        if (m_ph != P_RST) begin
            nout = m_out + int'(aw) - int'(b);
            if (nout < 0) nout = 0;
            if (nout > MAXT) nout = MAXT;
            nowed = m_owed + (aw ? int'(awlen) + 1 : 0) - int'(w);
            if (nowed < 0) nowed = 0;
            if (nowed > OWED_MAX) nowed = OWED_MAX;
        end
        m_out  = nout;
        m_owed = nowed;
        case (m_ph)
            P_IDLE: begin
                if (req) begin
                    m_ph = P_ISO;
                    m_tmr = DRC;
                end
            end
            P_ISO, P_DRN: begin
                t = m_tmr - 1;
                if ((m_ph == P_ISO ? nowed : nout) == 0) begin
                    if (m_ph == P_ISO) begin
                        m_ph = P_DRN;
                        m_tmr = DRC;
                    end else begin
                        m_ph = P_RST;
                        m_left = RSC;
                    end
                end else if (t == 0) begin
                    m_ph = P_RST;
                    m_left = RSC;
                    m_flag = 1'b1;
                end else begin
                    m_tmr = t;
                end
            end
            P_RST: begin
                m_left--;
                if (m_left == 0) begin
                    m_ph = P_CLR;
                    m_out = 0;
                    m_owed = 0;
                end
            end
            P_CLR: m_ph = P_WAIT;
            default: begin
                if (irq && !req) begin
                    m_ph = P_IDLE;
                    m_flag = 1'b0;
                end
            end
        endcase
    endtask

    task automatic tick();
        logic [8:0] obs;
        logic [8:0] exp;
        @(posedge clk);
        model_update();
        #1;
        exp = {3'(m_ph),
               (m_ph >= P_ISO && m_ph <= P_WAIT),
               (m_ph >= P_DRN && m_ph <= P_WAIT),
               (m_ph != P_RST),
               (m_ph == P_CLR),
               m_flag,
               (m_ph != P_IDLE)};
        obs = {state, gate_aw, gate_w, slv_rst_n, txn_clear, drain_to, busy};
        chk("outputs", 32'(obs), 32'(exp));
        chk("out_cnt", 32'(dut.out_cnt), m_out);
        chk("beats_owed", 32'(dut.beats_owed), m_owed);
        if (!slv_rst_n) rst_lo_cnt++;
        if (txn_clear) clr_cnt++;
        if (busy) busy_cnt++;
        if (state == 3'd2) drain_cnt++;
    endtask

    task automatic clr_obs();
        rst_lo_cnt = 0;
        clr_cnt = 0;
        busy_cnt = 0;
        drain_cnt = 0;
    endtask

    task automatic do_aw(int len);
        awv = 1'b1;
        awr = 1'b1;
        awlen = 8'(len);
        tick();
        awv = 1'b0;
        awr = 1'b0;
    endtask

    task automatic do_w(int n);
        for (int i = 0; i < n; i++) begin
            wv = 1'b1;
            wr = 1'b1;
            tick();
        end
        wv = 1'b0;
        wr = 1'b0;
    endtask

    task automatic do_b(int n);
        for (int i = 0; i < n; i++) begin
            bv = 1'b1;
            br = 1'b1;
            tick();
        end
        bv = 1'b0;
        br = 1'b0;
    endtask

    task automatic pulse_req();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic run_until(int ph, int budget);
        int k;
        k = 0;
        while (m_ph != ph && k < budget) begin
            tick();
            k++;
        end
        chk("reach_phase", 32'(state), 32'(ph));
    endtask

    task automatic release_sw();
        irq = 1'b1;
        tick();
        irq = 1'b0;
    endtask

    initial begin
        // reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_slv_rst_n", 32'(slv_rst_n), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gates", 32'({gate_aw, gate_w}), 0);
        rst_n = 1'b1;
        tick();

        // idle traffic
        clr_obs();
        do_aw(3);
        do_aw(3);
        do_aw(3);
        chk("idle_peak", 32'(dut.out_cnt), 3);
        chk("idle_owed", 32'(dut.beats_owed), 12);
        do_w(12);
        do_b(3);
        chk("idle_out_end", 32'(dut.out_cnt), 0);
        chk("idle_owed_end", 32'(dut.beats_owed), 0);
        chk("idle_busy", 32'(busy_cnt), 0);

        // clean recovery
        clr_obs();
        do_aw(7);
        do_w(2);
        pulse_req();
        chk("clean_iso", 32'(state), 1);
        chk("clean_gate_aw", 32'(gate_aw), 1);
        do_w(6);
        chk("clean_drain", 32'(state), 2);
        do_b(1);
        chk("clean_reset", 32'(state), 3);
        run_until(P_WAIT, 40);
        tick();
        tick();
        chk("clean_wait_hold", 32'(state), 5);
        release_sw();
        chk("clean_idle", 32'(state), 0);
        chk("clean_rst_len", 32'(rst_lo_cnt), RSC);
        chk("clean_clr_pulses", 32'(clr_cnt), 1);
        chk("clean_timeout", 32'(drain_to), 0);

        // drain timeout
        clr_obs();
        do_aw(0);
        do_aw(0);
        do_w(2);
        pulse_req();
        run_until(P_RST, 30);
        chk("to_drain_len", 32'(drain_cnt), DRC);
        chk("to_flag", 32'(drain_to), 1);
        run_until(P_WAIT, 40);
        chk("to_flag_wait", 32'(drain_to), 1);
        release_sw();
        chk("to_flag_clear", 32'(drain_to), 0);

        // same-cycle clean drain and timer expiry
        do_aw(0);
        do_w(1);
        pulse_req();
        tick();
        chk("same_in_drain", 32'(state), 2);
        for (int i = 0; i < DRC - 1; i++) tick();
        do_b(1);
        chk("same_state", 32'(state), 3);
        chk("same_flag", 32'(drain_to), 0);
        run_until(P_WAIT, 40);
        release_sw();

        // re-request during RESET; minimum recovery length
        clr_obs();
        pulse_req();
        run_until(P_RST, 10);
        for (int i = 0; i < 5; i++) tick();
        pulse_req();
        run_until(P_WAIT, 40);
        release_sw();
        chk("rereq_rst_len", 32'(rst_lo_cnt), RSC);
        chk("rereq_clr", 32'(clr_cnt), 1);
        chk("min_busy", 32'(busy_cnt), RSC + 4);
        tick();
        tick();
        chk("rereq_no_restart", 32'(state), 0);

        // reset during DRAIN
        do_aw(1);
        do_w(2);
        pulse_req();
        tick();
        tick();
        chk("mid_drain", 32'(state), 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_slv", 32'(slv_rst_n), 1);
        chk("mid_rst_out", 32'(dut.out_cnt), 0);
        chk("mid_rst_owed", 32'(dut.beats_owed), 0);

        // reset during RESET releases the slave reset
        pulse_req();
        run_until(P_RST, 10);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_in_reset_slv", 32'(slv_rst_n), 1);
        chk("rst_in_reset_state", 32'(state), 0);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            awv = ($urandom_range(0, 3) == 0);
            awr = ($urandom_range(0, 1) == 0);
            awlen = 8'($urandom_range(0, 7));
            wv = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 3) != 0);
            bv = ($urandom_range(0, 2) == 0);
            br = ($urandom_range(0, 1) == 0);
            req = ($urandom_range(0, 39) == 0);
            irq = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
